// File: rtl/hyperbus_cs_ctrl_if.sv
// Handshake bundle between the HyperBus PHY transaction FSM
// and the chip-select sequencer.
interface hyperbus_cs_ctrl_if #(
  parameter int unsigned NR_CS = 2
) ();
  logic             cs_req_i;
  logic [NR_CS-1:0] cs_sel_i;
  logic             cs_release_i;
  logic             cs_ready_o;
  logic             tcsm_expire_o;
  logic             rwr_busy_o;
  logic             err_sel_o;

  modport master (
    output cs_req_i,
    output cs_sel_i,
    output cs_release_i,
    input  cs_ready_o,
    input  tcsm_expire_o,
    input  rwr_busy_o,
    input  err_sel_o
  );

  modport slave (
    input  cs_req_i,
    input  cs_sel_i,
    input  cs_release_i,
    output cs_ready_o,
    output tcsm_expire_o,
    output rwr_busy_o,
    output err_sel_o
  );
endinterface

// File: rtl/hyperbus_cs_ctrl.sv
// HyperBus chip-select sequencer: tCSS/tCSH/tCSM/tRWR on clk270.
// Define HYPERBUS_CS_STATS_EN to enable the trans_cnt_o counter.
module hyperbus_cs_ctrl #(
  parameter int unsigned NR_CS      = 2,
  parameter int unsigned CSS_CYCLES = 1,
  parameter int unsigned CSH_CYCLES = 1,
  parameter int unsigned TCSM_WIDTH = 12
) (
  input  logic                  clk270,
  input  logic                  rst_ni,
  hyperbus_cs_ctrl_if.slave     bus,
  input  logic [TCSM_WIDTH-1:0] cfg_tcsm_i,
  input  logic [3:0]            cfg_trwr_i,
  output logic [NR_CS-1:0]      hyper_cs_no,
  output logic [15:0]           trans_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACTIVE,
    S_HOLD,
    S_RECOVER
  } state_e;

  localparam logic [15:0] CSS_LAST = 16'(CSS_CYCLES - 1);
  localparam logic [15:0] CSH_LAST = 16'(CSH_CYCLES - 1);
  localparam logic [TCSM_WIDTH-1:0] T_ONE = TCSM_WIDTH'(1);

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [TCSM_WIDTH-1:0] tcsm_cnt_q, tcsm_cnt_d;
  logic [TCSM_WIDTH-1:0] tcsm_cfg_q, tcsm_cfg_d;
  logic [3:0]            trwr_q, trwr_d;
  logic [NR_CS-1:0]      cs_n_q, cs_n_d;
  logic                  pend_q, pend_d;
  logic                  ready_q, ready_d;
  logic                  expire_q, expire_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  sel_ok;
  logic                  rel_now;

  assign sel_ok = (bus.cs_sel_i != '0) &&
    ((bus.cs_sel_i & (bus.cs_sel_i - NR_CS'(1))) == '0);

  assign rel_now = pend_q | bus.cs_release_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tcsm_cnt_d = tcsm_cnt_q;
    tcsm_cfg_d = tcsm_cfg_q;
    trwr_d     = trwr_q;
    cs_n_d     = cs_n_q;
    pend_d     = pend_q;
    ready_d    = ready_q;
    expire_d   = expire_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cs_req_i) begin
          if (sel_ok) begin
            state_d    = S_SETUP;
            cs_n_d     = ~bus.cs_sel_i;
            cnt_d      = '0;
            pend_d     = 1'b0;
            tcsm_cfg_d = cfg_tcsm_i;
            trwr_d     = cfg_trwr_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        pend_d = rel_now;
        if (cnt_q == CSS_LAST) begin
          cnt_d = '0;
          if (rel_now) begin
            state_d = S_HOLD;
          end else begin
            state_d    = S_ACTIVE;
            ready_d    = 1'b1;
            tcsm_cnt_d = '0;
            expire_d   = (tcsm_cfg_q == T_ONE);
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACTIVE: begin
        if (bus.cs_release_i) begin
          state_d  = S_HOLD;
          cnt_d    = '0;
          ready_d  = 1'b0;
          expire_d = 1'b0;
        end else begin
          // Saturate so a very long burst never re-fires the limit.
          if (!(&tcsm_cnt_q))
            tcsm_cnt_d = tcsm_cnt_q + T_ONE;
          if ((tcsm_cfg_q != '0) &&
              (tcsm_cnt_d == tcsm_cfg_q - T_ONE))
            expire_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == CSH_LAST) begin
          cs_n_d = '1;
          cnt_d  = '0;
          if (trwr_q != 4'd0) begin
            state_d = S_RECOVER;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RECOVER: begin
        if (cnt_q == {12'd0, trwr_q} - 16'd1) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = '1;
      end
    endcase
  end

  always_ff @(posedge clk270 or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tcsm_cnt_q <= '0;
      tcsm_cfg_q <= '0;
      trwr_q     <= '0;
      cs_n_q     <= '1;
      pend_q     <= 1'b0;
      ready_q    <= 1'b0;
      expire_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tcsm_cnt_q <= tcsm_cnt_d;
      tcsm_cfg_q <= tcsm_cfg_d;
      trwr_q     <= trwr_d;
      cs_n_q     <= cs_n_d;
      pend_q     <= pend_d;
      ready_q    <= ready_d;
      expire_q   <= expire_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign hyper_cs_no       = cs_n_q;
  assign bus.cs_ready_o    = ready_q;
  assign bus.tcsm_expire_o = expire_q;
  assign bus.rwr_busy_o    = busy_q;
  assign bus.err_sel_o     = err_q;

`ifdef HYPERBUS_CS_STATS_EN
  logic [15:0] trans_cnt_q, trans_cnt_d;
  logic        hold_done;

  assign hold_done = (state_q == S_HOLD) && (cnt_q == CSH_LAST);

  always_comb begin
    trans_cnt_d = trans_cnt_q;
    if (hold_done && !(&trans_cnt_q))
      trans_cnt_d = trans_cnt_q + 16'd1;
  end

  always_ff @(posedge clk270 or negedge rst_ni) begin
    if (!rst_ni) trans_cnt_q <= '0;
    else         trans_cnt_q <= trans_cnt_d;
  end

  assign trans_cnt_o = trans_cnt_q;
`else
  assign trans_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_hyperbus_cs_ctrl.sv
// Randomized bench for hyperbus_cs_ctrl against a timeline model
// that derives every output from per-transaction edge timestamps.
module tb_hyperbus_cs_ctrl;
  localparam int NR_CS = 2;
  localparam int CSS   = 1;
  localparam int CSH   = 1;
  localparam int TW    = 12;
  localparam longint INF = 64'd1000000000;

  logic              clk270 = 1'b0;
  logic              rst_ni = 1'b0;
  logic [TW-1:0]     cfg_tcsm = '0;
  logic [3:0]        cfg_trwr = '0;
  logic [NR_CS-1:0]  hyper_cs_no;
  logic [15:0]       trans_cnt;

  hyperbus_cs_ctrl_if #(.NR_CS(NR_CS)) bus ();

  hyperbus_cs_ctrl #(
    .NR_CS      (NR_CS),
    .CSS_CYCLES (CSS),
    .CSH_CYCLES (CSH),
    .TCSM_WIDTH (TW)
  ) dut (
    .clk270      (clk270),
    .rst_ni      (rst_ni),
    .bus         (bus.slave),
    .cfg_tcsm_i  (cfg_tcsm),
    .cfg_trwr_i  (cfg_trwr),
    .hyper_cs_no (hyper_cs_no),
    .trans_cnt_o (trans_cnt)
  );

  always #5 clk270 = ~clk270;

  int vectors = 0;
  int miscompares = 0;

  // Timeline model: edge index n, accept edge, hold start edge.
  longint           n;
  longint           acc;
  longint           hold_start;
  longint           err_edge;
  bit               have;
  bit               pend;
  logic [NR_CS-1:0] m_sel;
  longint           m_tcsm;
  longint           m_trwr;
  int               done_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h edge=%0d t=%0t",
               tag, got, exp, n, $time);
    end
  endtask

  function automatic bit onehot(input logic [NR_CS-1:0] s);
    int c = 0;
    for (int i = 0; i < NR_CS; i++) c += int'(s[i]);
    return c == 1;
  endfunction

  function automatic bit idle_at(input longint e);
    if (!have) return 1'b1;
    if (hold_start == INF) return 1'b0;
    return e > hold_start + CSH + m_trwr;
  endfunction

  task automatic model_reset();
    n = 0; have = 0; pend = 0; acc = 0;
    hold_start = INF; err_edge = -1;
    m_sel = '0; m_tcsm = 0; m_trwr = 0; done_cnt = 0;
  endtask

  task automatic model_step(input bit req,
                            input logic [NR_CS-1:0] sel,
                            input bit rel);
    if (idle_at(n)) begin
      if (req) begin
        if (onehot(sel)) begin
          have = 1; pend = 0; acc = n; m_sel = sel;
          m_tcsm = longint'(cfg_tcsm);
          m_trwr = longint'(cfg_trwr);
          hold_start = INF;
        end else begin
          err_edge = n;
        end
      end
    end else if (rel && hold_start == INF) begin
      if (n <= acc + CSS) begin
        pend = 1; hold_start = acc + CSS;
      end else begin
        hold_start = n;
      end
    end
    if (have && hold_start != INF && n == hold_start + CSH)
      done_cnt++;
  endtask

  task automatic check_all();
    bit cs_low, rdy, expd, bsy, errx;
    logic [NR_CS-1:0] cs_exp;
    cs_low = have && n >= acc && n < hold_start + CSH;
    rdy = have && !pend && n >= acc + CSS && n < hold_start;
    expd = rdy && m_tcsm != 0 && n >= acc + CSS + m_tcsm - 1;
    bsy = have && hold_start != INF && n >= hold_start + CSH &&
          n < hold_start + CSH + m_trwr;
    errx = (err_edge == n);
    cs_exp = cs_low ? ~m_sel : '1;
    chk("cs_no", 32'(hyper_cs_no), 32'(cs_exp));
    chk("ready", 32'(bus.cs_ready_o), 32'(rdy));
    chk("expire", 32'(bus.tcsm_expire_o), 32'(expd));
    chk("busy", 32'(bus.rwr_busy_o), 32'(bsy));
    chk("err_sel", 32'(bus.err_sel_o), 32'(errx));
`ifdef HYPERBUS_CS_STATS_EN
    chk("trans_cnt", 32'(trans_cnt), 32'(done_cnt));
`else
    chk("trans_cnt", 32'(trans_cnt), 32'd0);
`endif
  endtask

  task automatic cyc(input bit req,
                     input logic [NR_CS-1:0] sel,
                     input bit rel);
    bus.cs_req_i     = req;
    bus.cs_sel_i     = sel;
    bus.cs_release_i = rel;
    @(posedge clk270);
    n++;
    model_step(req, sel, rel);
    @(negedge clk270);
    check_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic async_reset();
    #2;
    rst_ni = 1'b0;
    bus.cs_req_i = 1'b0;
    bus.cs_release_i = 1'b0;
    #1;
    chk("rst_cs_no", 32'(hyper_cs_no), 32'(2'b11));
    chk("rst_ready", 32'(bus.cs_ready_o), 32'd0);
    chk("rst_expire", 32'(bus.tcsm_expire_o), 32'd0);
    chk("rst_busy", 32'(bus.rwr_busy_o), 32'd0);
    chk("rst_trans", 32'(trans_cnt), 32'd0);
    @(negedge clk270);
    @(negedge clk270);
    rst_ni = 1'b1;
    model_reset();
    check_all();
  endtask

  initial begin
    bus.cs_req_i = 1'b0;
    bus.cs_sel_i = '0;
    bus.cs_release_i = 1'b0;
    model_reset();
    @(negedge clk270);
    chk("por_cs_no", 32'(hyper_cs_no), 32'(2'b11));
    @(negedge clk270);
    rst_ni = 1'b1;
    check_all();

    cfg_tcsm = '0; cfg_trwr = 4'd3;
    cyc(1'b1, 2'b01, 1'b0);
    idle(10);
    cyc(1'b0, '0, 1'b1);
    idle(6);

    cfg_tcsm = TW'(8);
    cyc(1'b1, 2'b10, 1'b0);
    idle(12);
    cyc(1'b0, '0, 1'b1);
    idle(6);

    cyc(1'b1, 2'b11, 1'b0);
    idle(1);
    cyc(1'b1, 2'b00, 1'b0);
    idle(2);

    cfg_trwr = 4'd1;
    cyc(1'b1, 2'b01, 1'b0);
    cyc(1'b0, '0, 1'b1);
    idle(5);

    cfg_tcsm = '0; cfg_trwr = 4'd2;
    cyc(1'b1, 2'b01, 1'b0);
    idle(3);
    cyc(1'b1, 2'b10, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b0, '0, 1'b1);
    idle(6);

    cyc(1'b1, 2'b01, 1'b0);
    idle(3);
    async_reset();

    for (int t = 0; t < 5; t++) begin
      cyc(1'b1, 2'b01, 1'b0);
      idle(1);
      cyc(1'b0, '0, 1'b1);
      idle(4);
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        cfg_tcsm = TW'($urandom_range(0, 12));
        cfg_trwr = 4'($urandom_range(0, 4));
      end
      cyc($urandom_range(0, 3) == 0,
          NR_CS'($urandom_range(0, 3)),
          $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
